// File: rtl/fetch_sequencer.sv
// Sequential instruction fetch front end.
// Owns the fetch PC, issues word-aligned fetch requests, and buffers in-order
// responses, tagged with their PC, for decode. A redirect flushes buffered
// entries and discards any responses still in flight.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2,
   parameter int unsigned CNT_W     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        busy
);

   localparam int unsigned      PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned      INF_W    = CNT_W + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
   localparam logic [INF_W-1:0] DEPTH_W  = INF_W'(BUF_DEPTH);

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t           r_state;
   logic [31:0]      r_fetch_pc;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_drop_cnt;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_tag_rd_ptr;
   logic [PTR_W-1:0] r_tag_wr_ptr;
   logic [31:0]      r_data_mem [BUF_DEPTH];
   logic [31:0]      r_pc_mem   [BUF_DEPTH];
   logic [31:0]      r_tag_mem  [BUF_DEPTH];

   logic [INF_W-1:0] w_inflight;
   logic             w_req_valid;
   logic             w_accept;
   logic             w_rsp_keep;
   logic             w_rsp_drop;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_out_after_rsp;
   logic [CNT_W-1:0] w_out_next;
   logic [CNT_W-1:0] w_drop_next;
   logic [CNT_W-1:0] w_count_next;
   logic [31:0]      w_redirect_tgt;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Request gating, handshakes and next-value arithmetic for the counters.
   always_comb begin
      w_inflight      = {1'b0, r_outstanding} + {1'b0, r_count};
      // rst_n in the gate forces the request low as soon as reset asserts,
      // without waiting for a clock edge.
      w_req_valid     = rst_n && (r_state == ST_FETCH) && !halt && !redirect &&
                        (w_inflight < DEPTH_W);
      w_accept        = w_req_valid && imem_req_ready;
      w_rsp_keep      = imem_rsp_valid && (r_drop_cnt == '0);
      w_rsp_drop      = imem_rsp_valid && (r_drop_cnt != '0);
      w_push          = w_rsp_keep && !redirect;
      w_pop           = (r_count != '0) && inst_ready && !redirect;
      w_out_after_rsp = r_outstanding - CNT_W'(imem_rsp_valid);
      w_out_next      = r_outstanding + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);
      w_drop_next     = r_drop_cnt - CNT_W'(w_rsp_drop);
      w_count_next    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      w_redirect_tgt  = redirect_pc & 32'hFFFF_FFFC;
   end

   // Control state: fetch PC, counters, FIFO pointers and FETCH/DRAIN state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_FETCH;
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_tag_rd_ptr  <= '0;
         r_tag_wr_ptr  <= '0;
      end else if (redirect) begin
         // Every request still outstanding after this cycle's response (which
         // is itself discarded) belongs to the abandoned path, so the new
         // drop count equals the remaining outstanding count.
         r_fetch_pc    <= w_redirect_tgt;
         r_outstanding <= w_out_after_rsp;
         r_drop_cnt    <= w_out_after_rsp;
         r_state       <= (w_out_after_rsp != '0) ? ST_DRAIN : ST_FETCH;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_tag_rd_ptr  <= '0;
         r_tag_wr_ptr  <= '0;
      end else begin
         if (w_accept) begin
            r_fetch_pc   <= r_fetch_pc + 32'd4;
            r_tag_wr_ptr <= f_inc(r_tag_wr_ptr);
         end
         if (w_push) begin
            r_wr_ptr     <= f_inc(r_wr_ptr);
            r_tag_rd_ptr <= f_inc(r_tag_rd_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_inc(r_rd_ptr);
         end
         r_outstanding <= w_out_next;
         r_drop_cnt    <= w_drop_next;
         r_count       <= w_count_next;
         r_state       <= (w_drop_next != '0) ? ST_DRAIN : ST_FETCH;
      end
   end

   // Storage for request tags and buffered {instruction, pc} entries.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tag_mem[r_tag_wr_ptr] <= r_fetch_pc;
      end
      if (w_push) begin
         r_data_mem[r_wr_ptr] <= imem_rsp_data;
         r_pc_mem[r_wr_ptr]   <= r_tag_mem[r_tag_rd_ptr];
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = r_fetch_pc;
   assign inst_valid     = (r_count != '0);
   assign inst           = inst_valid ? r_data_mem[r_rd_ptr] : '0;
   assign inst_pc        = inst_valid ? r_pc_mem[r_rd_ptr]   : '0;
   assign busy           = (r_outstanding != '0) || (r_state == ST_DRAIN);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural program counter and runs sequential instruction fetch from instruction memory.
- Issues fetch requests over a valid/ready request channel and buffers in-order responses in a small FIFO.
- Presents each instruction with its PC to decode over a valid/ready channel.
- Is the producer of `pc` and the consumer of `next_pc` for the branching unit. A taken branch or jump arrives as a redirect, which flushes all in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BUF_DEPTH, 2, instruction FIFO entries; also the cap on (outstanding + buffered). Legal range 2..8.
- CNT_W, 4, width of the outstanding and drop counters; must satisfy 2^CNT_W > BUF_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- halt  in  1  level; while 1, no new fetch requests are issued.
- redirect  in  1  pulse; load redirect_pc and flush.
- redirect_pc  in  32  target from branching unit next_pc; bits [1:0] are ignored (forced 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address (word aligned).
- imem_rsp_valid  in  1  response valid; in-order; never back-pressured.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head valid to decode.
- inst_ready  in  1  decode accepts head.
- inst  out  32  head instruction.
- inst_pc  out  32  PC of head instruction (feeds branching unit pc).
- busy  out  1  1 when outstanding != 0 or state == DRAIN.

Behaviour:

Reset (async, rst_n = 0):
- fetch_pc = RESET_PC; outstanding = 0; drop_cnt = 0; FIFO empty; state = FETCH.
- All outputs 0 except imem_addr = RESET_PC.

Request issue:
- imem_req_valid = (state == FETCH) && !halt && !redirect && (outstanding + fifo_count < BUF_DEPTH).
- imem_addr = fetch_pc.
- A request is accepted on any cycle with valid && ready. On acceptance: fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Once valid is asserted, imem_addr is held stable until the request is accepted, unless a redirect occurs.

Response handling:
- Response with drop_cnt == 0: push {data, pc_tag} to FIFO and decrement outstanding.
  - pc_tag comes from a parallel tag FIFO of request addresses, pushed on accept and popped on response.
  - FIFO overflow is impossible by construction.
- Response with drop_cnt != 0: discard, drop_cnt -= 1, outstanding -= 1.

Decode side:
- inst_valid = FIFO non-empty; inst and inst_pc = head entry.
- Pop on inst_valid && inst_ready.
- A push to an empty FIFO becomes visible the next cycle (1-cycle response-to-decode latency).
- Push and pop in the same cycle are allowed when non-empty.

Redirect (takes priority over every other event in its cycle):
- fetch_pc <= {redirect_pc[31:2], 2'b00}.
- Data FIFO and tag FIFO cleared; any same-cycle pop is ignored.
- drop_cnt <= outstanding minus 1 if a response arrives that cycle (that response is discarded).
- Any same-cycle request acceptance is impossible because imem_req_valid is gated off by redirect.
- Next state = DRAIN if the new drop_cnt != 0, else FETCH.

State machine:
- FETCH: normal operation; go to DRAIN on a redirect with in-flight requests.
- DRAIN: no requests issued. Stay until the cycle the last dropped response arrives; FETCH the next cycle.
- A redirect during DRAIN reloads fetch_pc. drop_cnt is unchanged apart from that cycle's response, since no new requests were issued.

Halt:
- Only gates new requests. Outstanding responses still complete and fill the FIFO. Decode continues draining.

Invariants:
- outstanding + fifo_count <= BUF_DEPTH.
- drop_cnt <= outstanding.
- Instructions reach decode in program order with correct inst_pc.

Test Plan:
1. Reset then run, zero-latency memory, ready always 1, inst_ready = 1:
   - Required: inst_pc sequence 0x0, 0x4, 0x8, 0xC with matching data.
   - Required: imem_req_valid never asserted when outstanding + count = 2.
2. Back-pressure, inst_ready = 0 for 10 cycles:
   - Required: at most 2 requests issued; inst_valid = 1 held with inst_pc = 0x0.
   - Required: after release, 0x0 and 0x4 delivered in order, fetch resumes at 0x8.
3. Redirect with 2 outstanding (memory latency 3), redirect_pc = 0x1003:
   - Required: state DRAIN, both responses dropped.
   - Required: next request address is 0x1000, first inst_pc = 0x1000.
4. Redirect on the same cycle as a response arrival and an inst_ready pop:
   - Required: response discarded, FIFO empty next cycle, drop_cnt = outstanding − 1.
5. Wrap-around, redirect_pc = 0xFFFF_FFFC:
   - Required: fetch addresses 0xFFFF_FFFC then 0x0000_0000.
6. Halt asserted with 1 outstanding, then rst_n pulsed low mid-response:
   - Required: while halt is high, the outstanding response still lands in the FIFO and no new request is issued.
   - Required: on rst_n low, outputs go to 0 immediately (asynchronously) and imem_addr = RESET_PC.
